// File: rtl/plane_inlier_counter_if.sv
// Fixed-point types shared by the RANSAC blocks, and the plane/point/result
// handshake bundle of the inlier counter.
package ransac_fixed;
  localparam int frac_bits  = 16;
  localparam int fixed_bits = 32;
  localparam int full_bits  = 2 * fixed_bits;

  function automatic int value_bits();
    return fixed_bits;
  endfunction

  typedef logic signed [fixed_bits-1:0] fixed_t;

  typedef struct packed {
    fixed_t x;
    fixed_t y;
    fixed_t z;
  } point_t;

  typedef struct packed {
    point_t n;
    fixed_t d;
  } plane_t;

  function automatic fixed_t axis(point_t p, int idx);
    case (idx)
      0:       return p.x;
      1:       return p.y;
      default: return p.z;
    endcase
  endfunction

  // Full-width product, rescaled by the fraction bits with floor rounding
  function automatic fixed_t fx_mul(fixed_t a, fixed_t b);
    logic signed [full_bits-1:0] full;
    full = full_bits'(a) * full_bits'(b);
    return fixed_t'(full >>> frac_bits);
  endfunction
endpackage

interface plane_inlier_counter_if #(
  parameter int count_bits  = 32,
  parameter int points_bits = count_bits
);
  ransac_fixed::plane_t   plane;
  ransac_fixed::fixed_t   threshold;
  logic [points_bits-1:0] num_points;
  logic                   plane_valid;
  logic                   plane_ready;
  ransac_fixed::point_t   point;
  logic                   point_valid;
  logic                   point_ready;
  logic                   result_valid;
  logic                   is_inlier;
  logic                   count_valid;
  logic [count_bits-1:0]  inlier_count;
  logic                   count_ready;

  modport master (
    output plane, threshold, num_points, plane_valid, point, point_valid, count_ready,
    input  plane_ready, point_ready, result_valid, is_inlier, count_valid, inlier_count
  );

  modport slave (
    input  plane, threshold, num_points, plane_valid, point, point_valid, count_ready,
    output plane_ready, point_ready, result_valid, is_inlier, count_valid, inlier_count
  );
endinterface

// File: rtl/plane_inlier_counter.sv
// Streams points against a latched plane, flags each point whose distance is
// within the threshold, and reports the saturating inlier count per job.
module plane_inlier_counter #(
  parameter int multiply_latency = ransac_fixed::value_bits() / 16,
  parameter int count_bits       = 32,
  parameter int points_bits      = count_bits
) (
  input logic                    clock,
  input logic                    reset,
  plane_inlier_counter_if.slave  bus
);
  import ransac_fixed::*;

  localparam int sum_bits = fixed_bits + 2;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t                 state_reg;
  logic                   plane_ready_reg;
  logic                   point_ready_reg;
  logic                   count_valid_reg;
  logic [points_bits-1:0] accepted_reg;
  logic [points_bits-1:0] accepted_next;
  logic [count_bits-1:0]  inlier_count_reg;

  plane_t                 plane_reg;
  fixed_t                 threshold_reg;
  logic [points_bits-1:0] num_points_reg;

  logic                   in_valid_reg;
  point_t                 in_point_reg;
  logic [multiply_latency-1:0] prod_valid_reg;
  fixed_t                 prod_reg [multiply_latency][3];
  fixed_t                 stage0_prod [3];
  logic                   sum_valid_reg;
  logic signed [sum_bits-1:0] sum_reg;
  logic signed [sum_bits-1:0] sum_next;
  logic signed [sum_bits-1:0] abs_dist;
  logic signed [sum_bits-1:0] threshold_ext;
  logic                   inlier_next;
  logic                   result_valid_reg;
  logic                   is_inlier_reg;

  logic plane_fire;
  logic point_fire;
  logic pipe_busy;

  assign plane_fire    = bus.plane_valid && plane_ready_reg;
  assign point_fire    = bus.point_valid && point_ready_reg;
  assign pipe_busy     = in_valid_reg || (|prod_valid_reg) || sum_valid_reg || result_valid_reg;
  assign accepted_next = accepted_reg + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_axis
      assign stage0_prod[gi] = fx_mul(axis(in_point_reg, gi), axis(plane_reg.n, gi));
    end
  endgenerate

  // Four fixed_t terms fit in two extra bits without overflow
  assign sum_next = sum_bits'(prod_reg[multiply_latency-1][0])
                  + sum_bits'(prod_reg[multiply_latency-1][1])
                  + sum_bits'(prod_reg[multiply_latency-1][2])
                  - sum_bits'($signed(plane_reg.d));

  assign abs_dist      = sum_reg[sum_bits-1] ? -sum_reg : sum_reg;
  assign threshold_ext = sum_bits'(threshold_reg);
  assign inlier_next   = !threshold_reg[fixed_bits-1] && (abs_dist <= threshold_ext);

  // Datapath registers carry no reset; only their valid bits do
  always_ff @(posedge clock) begin
    if (plane_fire) begin
      plane_reg      <= bus.plane;
      threshold_reg  <= bus.threshold;
      num_points_reg <= bus.num_points;
    end
    in_point_reg <= bus.point;
    for (int s = multiply_latency - 1; s > 0; s--) begin
      prod_reg[s] <= prod_reg[s-1];
    end
    prod_reg[0] <= stage0_prod;
    sum_reg     <= sum_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      in_valid_reg     <= 1'b0;
      prod_valid_reg   <= '0;
      sum_valid_reg    <= 1'b0;
      result_valid_reg <= 1'b0;
      is_inlier_reg    <= 1'b0;
    end else begin
      in_valid_reg <= point_fire;
      for (int s = multiply_latency - 1; s > 0; s--) begin
        prod_valid_reg[s] <= prod_valid_reg[s-1];
      end
      prod_valid_reg[0] <= in_valid_reg;
      sum_valid_reg     <= prod_valid_reg[multiply_latency-1];
      result_valid_reg  <= sum_valid_reg;
      is_inlier_reg     <= sum_valid_reg && inlier_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= IDLE;
      plane_ready_reg  <= 1'b1;
      point_ready_reg  <= 1'b0;
      count_valid_reg  <= 1'b0;
      accepted_reg     <= '0;
      inlier_count_reg <= '0;
    end else begin
      if (result_valid_reg && is_inlier_reg && (inlier_count_reg != '1)) begin
        inlier_count_reg <= inlier_count_reg + 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (plane_fire) begin
            accepted_reg     <= '0;
            inlier_count_reg <= '0;
            plane_ready_reg  <= 1'b0;
            if (bus.num_points == '0) begin
              state_reg       <= DONE;
              count_valid_reg <= 1'b1;
            end else begin
              state_reg       <= STREAM;
              point_ready_reg <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (point_fire) begin
            accepted_reg <= accepted_next;
            if (accepted_next == num_points_reg) begin
              state_reg       <= DRAIN;
              point_ready_reg <= 1'b0;
            end
          end
        end
        // The last result has been folded into the count once every valid bit is clear
        DRAIN: begin
          if (!pipe_busy) begin
            state_reg       <= DONE;
            count_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (bus.count_ready) begin
            state_reg       <= IDLE;
            count_valid_reg <= 1'b0;
            plane_ready_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.plane_ready  = plane_ready_reg;
  assign bus.point_ready  = point_ready_reg;
  assign bus.result_valid = result_valid_reg;
  assign bus.is_inlier    = is_inlier_reg;
  assign bus.count_valid  = count_valid_reg;
  assign bus.inlier_count = inlier_count_reg;
endmodule

// File: tb/tb_plane_inlier_counter.sv
// Directed bench for plane_inlier_counter: nominal, boundary, zero-point,
// backpressure, mid-stream reset and count saturation jobs.
module tb_plane_inlier_counter;
  import ransac_fixed::*;

  localparam int L = 4;
  localparam fixed_t ONE     = 32'sd65536;
  localparam fixed_t HALF    = 32'sd32768;
  localparam fixed_t QUARTER = 32'sd16384;
  localparam fixed_t NEG_0P4 = -32'sd26214;
  localparam fixed_t TWO     = 32'sd131072;
  localparam fixed_t THREE   = 32'sd196608;
  localparam fixed_t X301    = 32'sd197263;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  plane_inlier_counter_if #(.count_bits(32)) a_if ();
  plane_inlier_counter_if #(.count_bits(4), .points_bits(8)) b_if ();

  plane_inlier_counter #(.count_bits(32)) dut_a (
    .clock (clk),
    .reset (rst),
    .bus   (a_if)
  );

  plane_inlier_counter #(.count_bits(4), .points_bits(8)) dut_b (
    .clock (clk),
    .reset (rst),
    .bus   (b_if)
  );

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     xfer_q[$];
  int     res_cyc_q[$];
  logic   res_flag_q[$];
  bit     pr_seen = 1'b0;
  int     b_results = 0;
  point_t pts[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_if.point_valid && a_if.point_ready) xfer_q.push_back(cyc + 1);
    if (a_if.result_valid) begin
      res_cyc_q.push_back(cyc);
      res_flag_q.push_back(a_if.is_inlier);
      $display("[%0d] result inlier=%0b", cyc, a_if.is_inlier);
    end
    if (a_if.point_ready) pr_seen = 1'b1;
    if (b_if.result_valid) b_results++;
  end

  task automatic check(string tag, longint obs, longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic plane_t mk_plane(fixed_t nx, fixed_t ny, fixed_t nz, fixed_t d);
    plane_t p;
    p.n.x = nx; p.n.y = ny; p.n.z = nz; p.d = d;
    return p;
  endfunction

  function automatic point_t mk_point(fixed_t x, fixed_t y, fixed_t z);
    point_t p;
    p.x = x; p.y = y; p.z = z;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    xfer_q.delete();
    res_cyc_q.delete();
    res_flag_q.delete();
  endtask

  task automatic start_job(plane_t p, fixed_t thr, int n);
    for (int i = 0; i < 20 && !a_if.plane_ready; i++) tick();
    check("plane_ready_before_job", a_if.plane_ready, 1);
    a_if.plane       = p;
    a_if.threshold   = thr;
    a_if.num_points  = n;
    a_if.plane_valid = 1'b1;
    tick();
    a_if.plane_valid = 1'b0;
  endtask

  task automatic send_points();
    foreach (pts[i]) begin
      a_if.point       = pts[i];
      a_if.point_valid = 1'b1;
      tick();
    end
    a_if.point_valid = 1'b0;
  endtask

  task automatic wait_count(string tag);
    for (int i = 0; i < 40 && !a_if.count_valid; i++) tick();
    check(tag, a_if.count_valid, 1);
  endtask

  task automatic finish_job(string tag);
    a_if.count_ready = 1'b1;
    tick();
    a_if.count_ready = 1'b0;
    check({tag, "_idle_plane_ready"}, a_if.plane_ready, 1);
    check({tag, "_idle_count_valid"}, a_if.count_valid, 0);
  endtask

  task automatic check_results(string tag, int n, logic [31:0] flags);
    check({tag, "_n_results"}, res_cyc_q.size(), n);
    for (int k = 0; k < n && k < res_cyc_q.size() && k < xfer_q.size(); k++) begin
      check($sformatf("%s_latency%0d", tag, k), res_cyc_q[k] - xfer_q[k], L);
      check($sformatf("%s_flag%0d", tag, k), res_flag_q[k], flags[k]);
    end
  endtask

  task automatic run_nominal(string tag);
    clear_log();
    start_job(mk_plane(0, 0, ONE, 0), HALF, 3);
    check({tag, "_stream_point_ready"}, a_if.point_ready, 1);
    check({tag, "_stream_plane_ready"}, a_if.plane_ready, 0);
    pts.delete();
    pts.push_back(mk_point(ONE, TWO, QUARTER));
    pts.push_back(mk_point(0, 0, NEG_0P4));
    pts.push_back(mk_point(THREE, THREE, ONE));
    send_points();
    wait_count({tag, "_count_valid"});
    check({tag, "_count"}, a_if.inlier_count, 2);
    check_results(tag, 3, 32'b011);
    finish_job(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    a_if.plane = '0; a_if.threshold = '0; a_if.num_points = '0; a_if.plane_valid = 1'b0;
    a_if.point = '0; a_if.point_valid = 1'b0; a_if.count_ready = 1'b0;
    b_if.plane = '0; b_if.threshold = '0; b_if.num_points = '0; b_if.plane_valid = 1'b0;
    b_if.point = '0; b_if.point_valid = 1'b0; b_if.count_ready = 1'b0;

    rst = 1'b1;
    tick();
    tick();
    check("rst_plane_ready", a_if.plane_ready, 1);
    check("rst_point_ready", a_if.point_ready, 0);
    check("rst_result_valid", a_if.result_valid, 0);
    check("rst_is_inlier", a_if.is_inlier, 0);
    check("rst_count_valid", a_if.count_valid, 0);
    check("rst_inlier_count", a_if.inlier_count, 0);
    rst = 1'b0;
    tick();

    run_nominal("nom");

    // Equality with the threshold counts as an inlier
    clear_log();
    start_job(mk_plane(ONE, 0, 0, TWO), ONE, 3);
    pts.delete();
    pts.push_back(mk_point(THREE, 0, 0));
    pts.push_back(mk_point(ONE, 0, 0));
    pts.push_back(mk_point(X301, 0, 0));
    send_points();
    wait_count("bnd_count_valid");
    check("bnd_count", a_if.inlier_count, 2);
    check_results("bnd", 3, 32'b011);
    finish_job("bnd");

    clear_log();
    pr_seen = 1'b0;
    start_job(mk_plane(0, 0, ONE, 0), HALF, 0);
    check("zero_count_valid", a_if.count_valid, 1);
    check("zero_count", a_if.inlier_count, 0);
    check("zero_point_ready", a_if.point_ready, 0);
    tick();
    finish_job("zero");
    check("zero_point_ready_never", pr_seen, 0);

    // Gapped points with ignored plane_valid, then count held under backpressure
    clear_log();
    start_job(mk_plane(0, 0, ONE, 0), HALF, 2);
    a_if.point = mk_point(ONE, ONE, 0);
    a_if.point_valid = 1'b1;
    tick();
    a_if.point_valid = 1'b0;
    a_if.plane = mk_plane(ONE, 0, 0, 0);
    a_if.plane_valid = 1'b1;
    tick();
    tick();
    a_if.plane_valid = 1'b0;
    a_if.point = mk_point(0, 0, TWO);
    a_if.point_valid = 1'b1;
    tick();
    a_if.point_valid = 1'b0;
    wait_count("bp_count_valid");
    a_if.point = mk_point(0, 0, 0);
    a_if.point_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold_valid%0d", i), a_if.count_valid, 1);
      check($sformatf("bp_hold_count%0d", i), a_if.inlier_count, 1);
    end
    a_if.point_valid = 1'b0;
    check_results("bp", 2, 32'b01);
    finish_job("bp");

    clear_log();
    start_job(mk_plane(0, 0, ONE, 0), HALF, 4);
    a_if.point = mk_point(0, 0, 0);
    a_if.point_valid = 1'b1;
    tick();
    tick();
    a_if.point_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("midrst_plane_ready", a_if.plane_ready, 1);
    check("midrst_count_valid", a_if.count_valid, 0);
    check("midrst_point_ready", a_if.point_ready, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("midrst_no_result", res_cyc_q.size(), 0);
    run_nominal("post_rst");

    // Narrow counter saturates at all-ones
    for (int i = 0; i < 20 && !b_if.plane_ready; i++) tick();
    check("sat_plane_ready", b_if.plane_ready, 1);
    b_if.plane = mk_plane(0, 0, ONE, 0);
    b_if.threshold = HALF;
    b_if.num_points = 8'd20;
    b_if.plane_valid = 1'b1;
    tick();
    b_if.plane_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      b_if.point = mk_point(fixed_t'(i * 65536), ONE, 0);
      b_if.point_valid = 1'b1;
      tick();
    end
    b_if.point_valid = 1'b0;
    for (int i = 0; i < 40 && !b_if.count_valid; i++) tick();
    check("sat_count_valid", b_if.count_valid, 1);
    check("sat_count", b_if.inlier_count, 15);
    check("sat_results", b_results, 20);
    b_if.count_ready = 1'b1;
    tick();
    b_if.count_ready = 1'b0;
    check("sat_idle", b_if.plane_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
